// File: rtl/gray_pkg.sv
// Shared types, limits and reference conversions for the streaming Gray code converter.
package gray_pkg;

    typedef enum logic {
        MODE_B2G = 1'b0,
        MODE_G2B = 1'b1
    } conv_mode_t;

    localparam int MAX_STAGES = 4;
    localparam int MAX_WIDTH  = 64;

    // Operands are zero-extended to MAX_WIDTH; leading zeros leave both conversions unchanged.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One pipeline register stage; resolves its slice of the gray->bin XOR chain, stage 0 also does bin->gray.
module gray_pipe_stage
    import gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic             mode_o,
    output logic [WIDTH-1:0] data_o
);

    // Bits above HI arrive already binary; bits HI..LO are resolved here, the rest stay Gray.
    localparam int SLICE = (WIDTH + STAGES - 1) / STAGES;
    localparam int HI    = WIDTH - 1 - IDX * SLICE;
    localparam int LO    = HI - SLICE + 1;

    logic             valid_q;
    logic             mode_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_i;
        if (mode_i == MODE_B2G) begin
            if (IDX == 0) begin
                data_d = WIDTH'(bin2gray(MAX_WIDTH'(data_i)));
            end
        end else begin
            for (int i = WIDTH - 2; i >= 0; i--) begin
                if (i <= HI && i >= LO) begin
                    data_d[i] = data_d[i+1] ^ data_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            mode_q  <= mode_i;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign data_o  = data_q;

endmodule

// File: rtl/gray_code_pipe.sv
// Streaming binary<->Gray converter: STAGES-deep stall-all pipeline with valid/ready on both sides.
module gray_code_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
);

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("gray_code_pipe: STAGES must be in 1..%0d", MAX_STAGES);
    end
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("gray_code_pipe: WIDTH must be in 1..%0d", MAX_WIDTH);
    end

    logic             advance;
    logic             vld_w  [STAGES+1];
    logic             mode_w [STAGES+1];
    logic [WIDTH-1:0] data_w [STAGES+1];

    // Whole chain moves together; a held output freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = !rst && advance;

    assign vld_w[0]  = in_valid;
    assign mode_w[0] = in_mode;
    assign data_w[0] = in_data;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gray_pipe_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (advance),
            .valid_i (vld_w[k]),
            .mode_i  (mode_w[k]),
            .data_i  (data_w[k]),
            .valid_o (vld_w[k+1]),
            .mode_o  (mode_w[k+1]),
            .data_o  (data_w[k+1])
        );
    end

    assign out_valid = vld_w[STAGES];
    assign out_mode  = mode_w[STAGES];
    assign out_data  = data_w[STAGES];

endmodule

// File: tb/tb_gray_code_pipe.sv
// Directed and randomised checks of gray_code_pipe at 4/2, 1/1 and 16/4 (WIDTH/STAGES).
module tb_gray_code_pipe;
    import gray_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
    logic [3:0]  a_in_data, a_out_data;
    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
    logic [15:0] b_in_data, b_out_data;
    logic        c_in_valid, c_in_ready, c_in_mode, c_out_valid, c_out_ready, c_out_mode;
    logic [0:0]  c_in_data, c_out_data;

    gray_code_pipe #(.WIDTH(4), .STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_mode(a_out_mode), .out_data(a_out_data));

    gray_code_pipe #(.WIDTH(16), .STAGES(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_mode(b_out_mode), .out_data(b_out_data));

    gray_code_pipe #(.WIDTH(1), .STAGES(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_mode(c_in_mode), .in_data(c_in_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_mode(c_out_mode), .out_data(c_out_data));

    typedef struct {
        logic       mode;
        logic [3:0] din;
        logic [3:0] dout;
    } vec_t;

    vec_t vec[$];
    logic [3:0] b2g_t [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [3:0] g2b_t [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h7, 4'h6, 4'h4, 4'h5,
                               4'hF, 4'hE, 4'hC, 4'hD, 4'h8, 4'h9, 4'hB, 4'hA};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        int rx;
        int n;
        rx = 0;
        n  = vec.size();
        a_out_ready = 1'b1;
        for (int t = 0; t < n + 4; t++) begin
            if (t < n) begin
                a_in_valid = 1'b1;
                a_in_mode  = vec[t].mode;
                a_in_data  = vec[t].din;
            end else begin
                a_in_valid = 1'b0;
            end
            tick();
            if (a_out_valid) begin
                if (rx < n) begin
                    chk($sformatf("tbl%0d_data", rx), 32'(a_out_data), 32'(vec[rx].dout));
                    chk($sformatf("tbl%0d_mode", rx), 32'(a_out_mode), 32'(vec[rx].mode));
                    chk($sformatf("tbl%0d_latency", rx), 32'(t - rx), 32'd1);
                end else begin
                    chk("tbl_extra_beat", 32'(rx), 32'(n));
                end
                rx++;
            end
        end
        chk("tbl_count", 32'(rx), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [16:0] q[$];
        logic [16:0] exp_b;
        int sent;
        int got;
        int guard;
        int n;

        rst = 1'b1;
        a_in_valid = 1'b0; a_in_mode = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_mode = 1'b0; c_in_data = '0; c_out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(a_in_ready), 32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'd0);
        chk("rst_out_mode", 32'(a_out_mode), 32'd0);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        chk("rst_c_out_valid", 32'(c_out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("post_rst_c_in_ready", 32'(c_in_ready), 32'd1);

        // WIDTH=1 / STAGES=1: identity in both modes, one cycle latency
        for (int i = 0; i < 4; i++) begin
            c_in_valid = 1'b1;
            c_in_mode  = i[1];
            c_in_data  = i[0:0];
            tick();
            c_in_valid = 1'b0;
            chk($sformatf("w1_%0d_valid", i), 32'(c_out_valid), 32'd1);
            chk($sformatf("w1_%0d_data", i), 32'(c_out_data), 32'(i[0]));
            chk($sformatf("w1_%0d_mode", i), 32'(c_out_mode), 32'(i[1]));
        end
        tick();
        chk("w1_idle", 32'(c_out_valid), 32'd0);

        // Directed, mixed-mode and exhaustive vectors streamed back to back
        vec.push_back('{1'b0, 4'hA, 4'hF});
        vec.push_back('{1'b1, 4'hF, 4'hA});
        vec.push_back('{1'b1, 4'h8, 4'hF});
        for (int i = 0; i < 3; i++) begin
            vec.push_back('{1'b0, 4'h5, 4'h7});
            vec.push_back('{1'b1, 4'h7, 4'h5});
        end
        for (int i = 0; i < 16; i++) vec.push_back('{1'b0, 4'(i), b2g_t[i]});
        for (int i = 0; i < 16; i++) vec.push_back('{1'b1, 4'(i), g2b_t[i]});
        run_table();

        // Backpressure: beats 1,2,3 bin->gray with the output held for 5 cycles
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_mode   = 1'b0;
        a_in_data   = 4'h1;
        tick();
        a_in_data = 4'h2;
        tick();
        a_in_data = 4'h3;
        #1;
        chk("bp_in_ready_drop", 32'(a_in_ready), 32'd0);
        chk("bp_first_data", 32'(a_out_data), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_stall%0d_in_ready", i), 32'(a_in_ready), 32'd0);
            chk($sformatf("bp_stall%0d_valid", i), 32'(a_out_valid), 32'd1);
            chk($sformatf("bp_stall%0d_data", i), 32'(a_out_data), 32'h1);
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_in_ready_back", 32'(a_in_ready), 32'd1);
        tick();
        a_in_valid = 1'b0;
        chk("bp_second_valid", 32'(a_out_valid), 32'd1);
        chk("bp_second_data", 32'(a_out_data), 32'h3);
        tick();
        chk("bp_third_valid", 32'(a_out_valid), 32'd1);
        chk("bp_third_data", 32'(a_out_data), 32'h2);
        tick();
        chk("bp_drained", 32'(a_out_valid), 32'd0);

        // Reset with two beats in flight
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_mode   = 1'b0;
        a_in_data   = 4'h5;
        tick();
        a_in_mode = 1'b1;
        a_in_data = 4'h7;
        tick();
        chk("mrst_pre_valid", 32'(a_out_valid), 32'd1);
        rst       = 1'b1;
        a_in_data = 4'h9;
        #1;
        chk("mrst_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        rst         = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        chk("mrst_out_valid", 32'(a_out_valid), 32'd0);
        chk("mrst_out_data", 32'(a_out_data), 32'd0);
        chk("mrst_out_mode", 32'(a_out_mode), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("mrst_stale%0d", i), 32'(a_out_valid), 32'd0);
        end

        // WIDTH=16 / STAGES=4: latency of an unstalled beat
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_mode   = 1'b0;
        b_in_data   = 16'h1234;
        tick();
        b_in_valid = 1'b0;
        n = 1;
        while (!b_out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("w16_latency", 32'(n), 32'd4);
        chk("w16_data", 32'(b_out_data), 32'h1B2E);
        tick();

        // WIDTH=16 / STAGES=4: 1000 random beats under random backpressure
        sent  = 0;
        got   = 0;
        guard = 0;
        while (got < 1000 && guard < 20000) begin
            b_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            b_in_mode   = 1'($urandom_range(0, 1));
            b_in_data   = 16'($urandom);
            b_out_ready = (sent >= 1000) || ($urandom_range(0, 3) != 0);
            #1;
            if (b_out_valid && b_out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_beat", 32'd1, 32'd0);
                end else begin
                    exp_b = q.pop_front();
                    chk($sformatf("rnd%0d_data", got), 32'(b_out_data), 32'(exp_b[15:0]));
                    chk($sformatf("rnd%0d_mode", got), 32'(b_out_mode), 32'(exp_b[16]));
                end
                got++;
            end
            if (b_in_valid && b_in_ready) begin
                if (b_in_mode) q.push_back({1'b1, 16'(gray2bin(64'(b_in_data)))});
                else           q.push_back({1'b0, 16'(bin2gray(64'(b_in_data)))});
                sent++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        b_in_valid = 1'b0;
        chk("rnd_count", 32'(got), 32'd1000);
        chk("rnd_leftover", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
